pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program counter for the core fetch stage; the next generation of the plain load/hold PC register.
- Each enabled cycle it selects the next PC from four sources: sequential increment, relative branch, absolute jump, or a return popped from an internal return-address stack (RAS).
- Feeds instruction memory address directly. Control inputs come from the decode/branch unit.

Parameters:
PC_W, 6, PC width in bits; all PC arithmetic is modulo 2^PC_W
INC, 1, sequential increment added to pc_out
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_VEC, 0, value loaded into pc_out on reset

Ports:
clck  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_write  in  1  1 = advance PC this cycle; 0 = stall (hold everything)
branch_taken  in  1  relative branch request
branch_off  in  PC_W  signed two's-complement branch offset, relative to pc_out
jump  in  1  absolute jump request
jump_target  in  PC_W  absolute jump address
call  in  1  jump to jump_target and push pc_out+INC onto RAS
ret  in  1  pop RAS top into PC
pc_out  out  PC_W  current PC (registered)
pc_next  out  PC_W  combinational value pc_out will take on the next enabled edge
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_ovf  out  1  sticky: a call was made while the RAS was full
ras_unf  out  1  sticky: a ret was made while the RAS was empty

Behaviour:
- Reset (async, immediate on rst=1):
  - pc_out=RESET_VEC.
  - RAS count=0, so ras_empty=1 and ras_full=0.
  - ras_ovf=0, ras_unf=0.
- Selection priority, evaluated when pc_write=1:
  1. ret, with RAS non-empty: pc_next=top; pop.
  2. ret, with RAS empty: pc_next=pc_out+INC; no pop; set ras_unf.
  3. call: pc_next=jump_target; push pc_out+INC.
  4. jump: pc_next=jump_target.
  5. branch_taken: pc_next=pc_out+branch_off (signed add, truncated to PC_W).
  6. otherwise: pc_next=pc_out+INC.
- Arithmetic: all sums wrap modulo 2^PC_W. With PC_W=6, 63+1=0 and 2+(-3)=63.
- Latency: pc_out updates on the rising edge after the request. pc_next is valid in the same cycle with zero latency.
- Stall (pc_write=0):
  - pc_out holds, no push/pop, sticky flags unchanged.
  - pc_next still reflects the selected value.
  - Request inputs are ignored and are not queued.
- Simultaneous call and ret: ret wins. The call is dropped entirely, with no push.
- Push while full:
  - RAS is circular; the oldest entry is overwritten and the new value becomes top.
  - Count stays RAS_DEPTH; ras_ovf is set.
  - A later ret returns the newest entries, LIFO.
- Pop while empty: handled as stated in the priority list (fall through, set ras_unf).
- Sticky flags clear only on rst.
- RAS implementation:
  - Storage array plus a top pointer of clog2(RAS_DEPTH) bits and a count of clog2(RAS_DEPTH)+1 bits.
  - Storage contents are don't-care after reset; count governs validity.
- Reset mid-operation: asserting rst during any command aborts it. The state returns to reset values asynchronously, and the first enabled edge after rst deasserts produces the selected next PC from RESET_VEC.

Decomposition:
- Shared package pc_pkg holds:
  - default PC_W;
  - a localparam enum for the next-PC source (SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET);
  - clog2 helper for pointer widths.
- Sub-module ras_stack(clck, rst, push, pop, din, dout, empty, full):
  - circular LIFO with overwrite-on-full;
  - instantiated once.
- pc_sequencer holds the priority mux, adders, PC register and sticky flags.

Test Plan:
1. Reset/sequential wrap (PC_W=6): rst pulse, then pc_write=1 with no requests for 65 cycles -> pc_out goes 0,1,...,63,0,1; ras_empty=1, flags 0.
2. Branch and jump: at pc_out=5, branch_taken, branch_off=6'h3D (-3) -> pc_out=2. Next cycle jump, jump_target=40 -> pc_out=40. Branch and jump both asserted at pc_out=40 -> jump wins -> 40.
3. Call/return nesting: at pc 10 call target 20; at 20 call target 30; then two rets -> pc_out sequence 20, 30, 21, 11; ras_empty=1 at end.
4. Overflow/underflow with RAS_DEPTH=4:
   - 5 calls from pcs 1,2,3,4,5 -> ras_ovf=1, ras_full=1.
   - 5 rets -> returns 6,5,4,3, then fall-through +INC with ras_unf=1.
5. Stall and simultaneous events:
   - pc_write=0 for 3 cycles while call asserted -> pc_out and RAS unchanged, pc_next=jump_target.
   - call+ret with RAS holding 12 -> pc_out=12, no push.
6. Async reset mid-operation: assert rst between clock edges while RAS holds 2 entries and ras_ovf=1 -> pc_out=RESET_VEC and flags 0 before the next edge; after release, a ret -> ras_unf=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default width,
// next-PC source encoding and a pointer-width helper.
package pc_pkg;

    localparam int PC_W_DEFAULT = 6;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_CALL = 3'd3,
        SRC_RET  = 3'd4
    } pc_src_e;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the decode/branch unit (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_W = pc_pkg::PC_W_DEFAULT
);
    logic            pc_write;
    logic            branch_taken;
    logic [PC_W-1:0] branch_off;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] pc_next;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output pc_write, branch_taken, branch_off, jump, jump_target, call, ret,
        input  pc_out, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  pc_write, branch_taken, branch_off, jump, jump_target, call, ret,
        output pc_out, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: LIFO whose push on a full stack overwrites
// the oldest entry while the count saturates at DEPTH.
module ras_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PC_W_DEFAULT
) (
    input  logic         clck,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[top_q];

    // The pointer wraps naturally because DEPTH is a power of two, so a push
    // on a full stack lands on the oldest slot.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            top_d = top_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clck) begin
        if (push) begin
            mem_q[top_d] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority selection among sequential, branch,
// jump, call and return sources, with a return-address stack and sticky errors.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int INC       = 1,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic           clck,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    pc_src_e         src;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] pc_sel;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_full;
    logic            ras_push, ras_pop;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clck  (clck),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq_pc),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // A ret always shadows call/jump/branch, even when it falls through on an
    // empty stack, so a simultaneous call never pushes.
    always_comb begin
        src = SRC_SEQ;
        if (bus.ret) begin
            src = ras_empty ? SRC_SEQ : SRC_RET;
        end else if (bus.call) begin
            src = SRC_CALL;
        end else if (bus.jump) begin
            src = SRC_JMP;
        end else if (bus.branch_taken) begin
            src = SRC_BR;
        end
    end

    always_comb begin
        seq_pc = pc_q + PC_W'(INC);
        case (src)
            SRC_RET:          pc_sel = ras_top;
            SRC_CALL, SRC_JMP: pc_sel = bus.jump_target;
            SRC_BR:           pc_sel = pc_q + bus.branch_off;
            default:          pc_sel = seq_pc;
        endcase
    end

    always_comb begin
        pc_d     = bus.pc_write ? pc_sel : pc_q;
        ras_push = bus.pc_write && (src == SRC_CALL);
        ras_pop  = bus.pc_write && (src == SRC_RET);
        ovf_d    = ovf_q | (ras_push & ras_full);
        unf_d    = unf_q | (bus.pc_write & bus.ret & ras_empty);
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            pc_q  <= PC_W'(RESET_VEC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_next   = pc_sel;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a queue-based reference model of the PC and return stack.
module tb_pc_sequencer;

    localparam int PC_W  = 6;
    localparam int MASK  = (1 << PC_W) - 1;
    localparam int INC   = 1;
    localparam int DEPTH = 4;
    localparam int RVEC  = 0;

    typedef struct {
        int pc;
        int nxt;
        bit empty;
        bit full;
        bit ovf;
        bit unf;
    } exp_t;

    logic clck;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 0;

    exp_t sb[$];

    int m_pc;
    int m_ras[$];
    bit m_ovf;
    bit m_unf;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(
        .PC_W      (PC_W),
        .INC       (INC),
        .RAS_DEPTH (DEPTH),
        .RESET_VEC (RVEC)
    ) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        clck = 1'b0;
        forever #5 clck = ~clck;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, predict this cycle's observables,
    // then advance the reference model as the coming edge should.
    task automatic applyStimulus(input bit r, input bit w, input bit bt, input int off,
                                 input bit j, input int t, input bit c, input bit rt);
        exp_t e;
        int   nxt;
        bit   do_push, do_pop, set_unf;
        @(negedge clck);
        #1;
        rst              = r;
        bus.pc_write     = w;
        bus.branch_taken = bt;
        bus.branch_off   = PC_W'(off);
        bus.jump         = j;
        bus.jump_target  = PC_W'(t);
        bus.call         = c;
        bus.ret          = rt;
        if (r) begin
            m_pc = RVEC;
            m_ras.delete();
            m_ovf = 0;
            m_unf = 0;
        end
        do_push = 0;
        do_pop  = 0;
        set_unf = 0;
        if (rt && m_ras.size() > 0) begin
            nxt    = m_ras[$];
            do_pop = 1;
        end else if (rt) begin
            nxt     = (m_pc + INC) & MASK;
            set_unf = 1;
        end else if (c) begin
            nxt     = t & MASK;
            do_push = 1;
        end else if (j) begin
            nxt = t & MASK;
        end else if (bt) begin
            nxt = (m_pc + int'($signed(PC_W'(off)))) & MASK;
        end else begin
            nxt = (m_pc + INC) & MASK;
        end
        e.pc    = m_pc;
        e.nxt   = nxt;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        if (w && !r) begin
            if (do_pop) begin
                void'(m_ras.pop_back());
            end
            if (do_push) begin
                if (m_ras.size() == DEPTH) begin
                    m_ovf = 1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back((m_pc + INC) & MASK);
            end
            if (set_unf) begin
                m_unf = 1;
            end
            m_pc = nxt;
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled the inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clck);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pc_out",    int'(bus.pc_out),    e.pc);
                checkOutput("pc_next",   int'(bus.pc_next),   e.nxt);
                checkOutput("ras_empty", int'(bus.ras_empty), int'(e.empty));
                checkOutput("ras_full",  int'(bus.ras_full),  int'(e.full));
                checkOutput("ras_ovf",   int'(bus.ras_ovf),   int'(e.ovf));
                checkOutput("ras_unf",   int'(bus.ras_unf),   int'(e.unf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.pc_write     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_off   = '0;
        bus.jump         = 1'b0;
        bus.jump_target  = '0;
        bus.call         = 1'b0;
        bus.ret          = 1'b0;
        m_pc  = RVEC;
        m_ovf = 0;
        m_unf = 0;

        $display("[TB] reset and sequential wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] branch and jump");
        while (m_pc != 5) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 6'h3D, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 40, 0, 0);
        applyStimulus(0, 1, 1, 7, 1, 40, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] call/return nesting");
        applyStimulus(0, 1, 0, 0, 1, 10, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 20, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 30, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] overflow and underflow");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, m_pc + 1, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] stall and simultaneous call/ret");
        applyStimulus(0, 1, 0, 0, 1, 11, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 50, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 33, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 44, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] async reset mid-operation");
        applyStimulus(0, 1, 0, 0, 0, 7, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 20, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 25, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, MASK)),
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, MASK)),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clck);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        stim_done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
